// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, opcode width and opcode encodings.
// Imported by the ALU, the arbiter and the arbitrated-ALU top.
package alu_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 3'b111;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU.
// Ports:
//   a, b   : operands
//   op     : opcode (alu_pkg encodings)
//   result : op(a, b); ADD/SUB wrap, shifts use b[4:0], SRA is signed
//   zero   : 1 when result == 0
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  input  logic [ALU_OP_W-1:0] op,
  output logic [XLEN-1:0]     result,
  output logic                zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      ALU_SRA: result = $unsigned($signed(a) >>> b[4:0]);
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter returning a one-hot grant and its index.
// Macro ALU_ARB_FIXED_PRIO_EN: when defined, lowest-index valid always wins
// and the last pointer is ignored; otherwise round-robin starting after last.
// Ports:
//   valid : per-requester request
//   last  : index of the most recent winner
//   en    : grant enable (grant forced to zero when low)
//   grant : one-hot grant, zero when en is low or nothing is valid
//   idx   : encoded winner index (meaningful when found)
//   found : at least one requester is valid
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] last,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] cand;

  // Scan high to low so the lowest valid index is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IDX_W'(i);
      if (valid[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end
`else
  localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Candidate order is last+1, last+2, ... modulo N; one spare bit holds
  // the sum before the single conditional wrap.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      sum = {1'b0, last} + (IDX_W + 1)'(i);
      if (sum >= N_EXT) sum = sum - N_EXT;
      cand = sum[IDX_W-1:0];
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
`endif

  assign grant = (found && en) ? (N'(1) << idx) : '0;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters with valid/ready handshakes and
// a single registered response channel carrying the owner's index.
// Macro ALU_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins, no
// round-robin pointer); default is round-robin.
// Ports:
//   clk_i, rst_i                       : clock, synchronous active-high reset
//   req_valid_i / req_ready_o          : per-requester handshake
//   req_a_i, req_b_i, req_op_i         : packed operands/opcodes, 32/32/3 bits each
//   rsp_valid_o / rsp_ready_i          : response handshake
//   rsp_id_o, rsp_result_o, rsp_zero_o : response owner, result, zero flag
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [XLEN*NUM_REQ-1:0]      req_a_i,
  input  logic [XLEN*NUM_REQ-1:0]      req_b_i,
  input  logic [ALU_OP_W*NUM_REQ-1:0]  req_op_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [ID_W-1:0]              rsp_id_o,
  output logic [XLEN-1:0]              rsp_result_o,
  output logic                         rsp_zero_o
);

  logic [XLEN-1:0]     a_arr  [NUM_REQ];
  logic [XLEN-1:0]     b_arr  [NUM_REQ];
  logic [ALU_OP_W-1:0] op_arr [NUM_REQ];

  logic               can_accept;
  logic               arb_en;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win;
  logic               found;
  logic               accept;
  logic [ID_W-1:0]    last_ptr;
  logic [XLEN-1:0]    alu_result;
  logic               alu_zero;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign a_arr[k]  = req_a_i[k*XLEN +: XLEN];
    assign b_arr[k]  = req_b_i[k*XLEN +: XLEN];
    assign op_arr[k] = req_op_i[k*ALU_OP_W +: ALU_OP_W];
  end

  // A held response blocks new grants; a draining one may be refilled.
  assign can_accept = !rsp_valid_o || rsp_ready_i;
  assign arb_en     = can_accept && !rst_i;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign last_ptr = '0;
`else
  logic [ID_W-1:0] last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)       last_q <= ID_W'(NUM_REQ - 1);
    else if (accept) last_q <= win;
  end

  assign last_ptr = last_q;
`endif

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .valid (req_valid_i),
    .last  (last_ptr),
    .en    (arb_en),
    .grant (grant),
    .idx   (win),
    .found (found)
  );

  assign req_ready_o = grant;
  assign accept      = found && arb_en;

  alu u_alu (
    .a      (a_arr[win]),
    .b      (b_arr[win]),
    .op     (op_arr[win]),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o  <= 1'b0;
      rsp_id_o     <= '0;
      rsp_result_o <= '0;
      rsp_zero_o   <= 1'b0;
    end else if (accept) begin
      rsp_valid_o  <= 1'b1;
      rsp_id_o     <= win;
      rsp_result_o <= alu_result;
      rsp_zero_o   <= alu_zero;
    end else if (rsp_ready_i) begin
      // Payload is kept after a drain; only valid drops.
      rsp_valid_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [3*N-1:0]  req_op;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_result;
  logic            rsp_zero;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_last;
  logic        m_valid;
  logic [1:0]  m_id;
  logic [31:0] m_result;
  logic        m_zero;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_op_i     (req_op),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_result_o (rsp_result),
    .rsp_zero_o   (rsp_zero)
  );

  function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    int sh;
    sh = int'(b % 32);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << sh;
      3'd6: return a >> sh;
      default: return 32'($signed(a) >>> sh);
    endcase
  endfunction

  function automatic int model_winner(logic [N-1:0] v);
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int i = 1; i <= N; i++) if (v[(m_last + i) % N]) return (m_last + i) % N;
`endif
    return -1;
  endfunction

  // Advance one clock: sample ready mid-cycle, predict, update the model at
  // the edge, return 1 time unit after the edge with registered outputs settled.
  task automatic step(output logic [N-1:0] obs, output logic [N-1:0] expv);
    int   w;
    logic can;
    @(negedge clk);
    obs  = req_ready;
    w    = model_winner(req_valid);
    can  = !m_valid || rsp_ready;
    expv = (!rst && w >= 0 && can) ? N'(1 << w) : '0;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_id = '0; m_result = '0; m_zero = 1'b0; m_last = N - 1;
    end else if (w >= 0 && can) begin
      m_result = alu_ref(req_a[w*32 +: 32], req_b[w*32 +: 32], req_op[w*3 +: 3]);
      m_zero   = (m_result == 0);
      m_id     = 2'(w);
      m_valid  = 1'b1;
      m_last   = w;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic reset_dut();
    logic [N-1:0] o, e;
    rst = 1'b1;
    step(o, e);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [N-1:0] o, e;
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
    req_a = {32'd1, 32'd1, 32'd1}; req_b = {32'd2, 32'd2, 32'd2}; req_op = '0;
    for (int i = 0; i < 2; i++) begin
      step(o, e);
      checks++;
      if (o !== '0) begin errors++; $display("FAIL reset_ready cyc%0d: got %b expected 000", i, o); end
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid cyc%0d: got %b expected 0", i, rsp_valid); end
    end
    rst = 1'b0;
    step(o, e);
    checks++;
    if (o !== 3'b001) begin errors++; $display("FAIL first_grant: got %b expected 001", o); end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'd3) begin
      errors++; $display("FAIL first_rsp: got v=%b id=%0d res=%h expected v=1 id=0 res=3", rsp_valid, rsp_id, rsp_result);
    end
  endtask

  task automatic test_single_op();
    logic [N-1:0] o, e;
    req_valid = 3'b001; rsp_ready = 1'b1;
    req_a[31:0] = 32'h0000_0005; req_b[31:0] = 32'hFFFF_FFFB; req_op[2:0] = 3'd0;
    step(o, e);
    req_valid = '0;
    checks++;
    if (o !== e) begin errors++; $display("FAIL single_ready: got %b expected %b", o, e); end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL single_rsp: got v=%b res=%h z=%b id=%0d expected v=1 res=0 z=1 id=0",
                         rsp_valid, rsp_result, rsp_zero, rsp_id);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] o, e;
    reset_dut();
    req_valid = '1; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_a = {$urandom, $urandom, $urandom}; req_b = {$urandom, $urandom, $urandom};
      req_op = 9'($urandom_range(0, 511));
      step(o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL rr_ready cyc%0d: got %b expected %b", i, o, e); end
      checks++;
      if (rsp_valid !== m_valid || rsp_id !== m_id || rsp_result !== m_result || rsp_zero !== m_zero) begin
        errors++; $display("FAIL rr_rsp cyc%0d: got v=%b id=%0d res=%h z=%b expected v=%b id=%0d res=%h z=%b",
                           i, rsp_valid, rsp_id, rsp_result, rsp_zero, m_valid, m_id, m_result, m_zero);
      end
`ifndef ALU_ARB_FIXED_PRIO_EN
      checks++;
      if (rsp_id !== 2'(i % 3)) begin errors++; $display("FAIL rr_order cyc%0d: got id %0d expected %0d", i, rsp_id, i % 3); end
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] o, e;
    reset_dut();
    req_valid = 3'b010; rsp_ready = 1'b1;
    req_a[63:32] = 32'h8000_0000; req_b[63:32] = 32'd4; req_op[5:3] = 3'd7;
    step(o, e);
    checks++;
    if (o !== 3'b010) begin errors++; $display("FAIL bp_accept: got %b expected 010", o); end
    req_valid = 3'b101; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(o, e);
      checks++;
      if (o !== '0) begin errors++; $display("FAIL bp_hold_ready cyc%0d: got %b expected 000", i, o); end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'hF800_0000 || rsp_id !== 2'd1 || rsp_zero !== 1'b0) begin
        errors++; $display("FAIL bp_hold_rsp cyc%0d: got v=%b res=%h id=%0d z=%b expected v=1 res=f8000000 id=1 z=0",
                           i, rsp_valid, rsp_result, rsp_id, rsp_zero);
      end
    end
    rsp_ready = 1'b1;
    step(o, e);
    checks++;
    if (o !== e || o === '0) begin errors++; $display("FAIL bp_release_ready: got %b expected %b", o, e); end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== m_id || rsp_result !== m_result) begin
      errors++; $display("FAIL bp_release_rsp: got v=%b id=%0d res=%h expected v=1 id=%0d res=%h",
                         rsp_valid, rsp_id, rsp_result, m_id, m_result);
    end
    req_valid = '0;
  endtask

  task automatic test_mid_reset();
    logic [N-1:0] o, e;
    req_valid = 3'b100; rsp_ready = 1'b1;
    step(o, e);
    req_valid = '0; rsp_ready = 1'b0;
    step(o, e);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("FAIL mr_held: got v=%b id=%0d expected v=1 id=2", rsp_valid, rsp_id); end
    rst = 1'b1;
    step(o, e);
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin
      errors++; $display("FAIL mr_dropped: got v=%b id=%0d res=%h z=%b expected all zero", rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
    req_valid = '1; rsp_ready = 1'b1;
    step(o, e);
    checks++;
    if (o !== 3'b001) begin errors++; $display("FAIL mr_first_grant: got %b expected 001", o); end
    req_valid = '0;
  endtask

`ifdef ALU_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    logic [N-1:0] o, e;
    reset_dut();
    req_valid = 3'b011; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(o, e);
      checks++;
      if (o !== 3'b001) begin errors++; $display("FAIL fp_grant cyc%0d: got %b expected 001", i, o); end
    end
    req_valid = '0;
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] o, e;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      req_valid = N'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_a     = {$urandom, $urandom, $urandom};
      req_b     = ($urandom_range(0, 3) == 0) ? req_a : {$urandom, $urandom, $urandom};
      req_op    = 9'($urandom_range(0, 511));
      step(o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL rand_ready cyc%0d: got %b expected %b", i, o, e); end
      checks++;
      if (rsp_valid !== m_valid || rsp_id !== m_id || rsp_result !== m_result || rsp_zero !== m_zero) begin
        errors++; $display("FAIL rand_rsp cyc%0d: got v=%b id=%0d res=%h z=%b expected v=%b id=%0d res=%h z=%b",
                           i, rsp_valid, rsp_id, rsp_result, rsp_zero, m_valid, m_id, m_result, m_zero);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_last = N - 1; m_valid = 1'b0; m_id = '0; m_result = '0; m_zero = 1'b0;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1; req_a = '0; req_b = '0; req_op = '0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
`ifdef ALU_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 32-bit ALU instance between NUM_REQ requesters, e.g. the execute stage, the address-generation unit and the branch-compare unit.
- Arbitration is round-robin. Each requester uses a valid/ready handshake.
- Results are registered and broadcast on a single response channel with a requester ID and backpressure.
- Sits between the issue logic and the ALU so the core carries one ALU instead of one per consumer.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- ID_W, derived localparam, $clog2(NUM_REQ); width of the response ID; not overridable.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- req_valid_i  input  NUM_REQ  per-requester request valid.
- req_ready_o  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a_i  input  32*NUM_REQ  operand A; requester k in bits [32k+31:32k].
- req_b_i  input  32*NUM_REQ  operand B; same packing as req_a_i.
- req_op_i  input  3*NUM_REQ  ALU opcode; requester k in bits [3k+2:3k].
- rsp_valid_o  output  1  response register holds a result.
- rsp_ready_i  input  1  consumer accepts the response.
- rsp_id_o  output  ID_W  index of the requester that owns the response.
- rsp_result_o  output  32  registered ALU result.
- rsp_zero_o  output  1  registered zero flag; 1 when rsp_result_o == 0.

Behaviour:
- Reset: rst_i is synchronous and active-high, sampled on the rising edge of clk_i. Reset values:
  - rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, rsp_zero_o=0.
  - Round-robin pointer last_q = NUM_REQ-1, so requester 0 has highest priority first.
  - req_ready_o is all-zero while rst_i is high.
  - Reset mid-operation drops any held response without handshake.
- can_accept = !rsp_valid_o || rsp_ready_i. Drain and refill in the same cycle is allowed, giving full throughput of one op per cycle.
- Grant (combinational):
  - Search req_valid_i starting at index (last_q+1) mod NUM_REQ, wrapping around.
  - The first valid index found is the winner.
  - req_ready_o[winner] = can_accept; all other bits are 0.
  - The grant depends on req_valid_i, last_q and rsp state only, never on operands.
- Accept: an accept occurs when req_valid_i[k] and req_ready_o[k] are both high. On that edge:
  - The ALU is fed with requester k's a/b/op.
  - rsp_result_o and rsp_zero_o capture the ALU outputs.
  - rsp_id_o = k, rsp_valid_o = 1, last_q = k.
- Latency: accept edge to rsp_valid_o high is 1 cycle.
- Hold: while rsp_valid_o && !rsp_ready_i:
  - Response registers are stable.
  - All req_ready_o bits are 0.
  - last_q is unchanged.
- Drain with no accept: rsp_valid_o goes to 0. rsp_id_o, rsp_result_o and rsp_zero_o keep their previous values.
- Requester protocol: once req_valid_i[k] is asserted, it and its operands stay stable until accepted. The block does not check this.
- No request valid: no grant and last_q is unchanged.
- Single requester repeatedly valid: it is granted every cycle that can_accept is high.
- Arithmetic: identical to the ALU.
  - 32-bit wrap-around on ADD and SUB.
  - Shift amount is b[4:0].
  - SRA is signed.
  - rsp_zero_o is computed from the same-cycle result, with no stale-value lag.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index valid requester always wins, and last_q is not instantiated.
- Undefined (default): round-robin as described above.
- All other timing and handshake rules are identical in both modes.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_XOR=3'b100, ALU_SLL=3'b101, ALU_SRL=3'b110, ALU_SRA=3'b111.
  - ALU_OP_W=3 and XLEN=32.
- One natural sub-module: rr_arbiter. It is parameterised by N and takes valid, last pointer and enable, and returns a one-hot grant plus the encoded index. The fixed-priority variant lives inside it under the macro.
- The existing alu module is instantiated once, unchanged, fed by the winner mux.

Test Plan:
- Reset: hold rst_i 2 cycles with all req_valid_i=1 -> req_ready_o=0 and rsp_valid_o=0 throughout. First post-reset grant goes to requester 0.
- Single op: req0 ADD a=0x0000_0005, b=0xFFFF_FFFB, rsp_ready_i=1 -> next cycle rsp_valid_o=1, result=0, zero=1, id=0.
- Round-robin (NUM_REQ=3): all valid continuously, rsp_ready_i=1 -> grants in order 0,1,2,0,1,2. One response per cycle, IDs in the same order.
- Backpressure: req1 SRA a=0x8000_0000, b=4 accepted, then rsp_ready_i=0 for 3 cycles -> response holds result=0xF800_0000, id=1 stable. All req_ready_o=0 during the hold. On release, the next accept happens in the same cycle as the drain.
- Mid-operation reset: response held with rsp_ready_i=0, assert rst_i one cycle -> rsp_valid_o=0 next cycle and last_q reset. Next grant goes to requester 0.
- ALU_ARB_FIXED_PRIO_EN defined, req0 and req1 continuously valid -> req0 is granted every cycle and req1 is never granted.
